// File: rtl/control_sequencer.sv
// control_sequencer: one-hot T-state sequencer with opcode latch, gated
// one-hot decode, stall, early end of execute, latched HALT and retire pulse.
// Optional feature macro: SINGLE_STEP_EN (adds the 'step' input; the
// sequencer waits in T1 until step=1). When undefined, step is treated as 1.
module control_sequencer #(
  parameter int unsigned         OPCODE_W = 4,
  parameter int unsigned         NUM_T    = 6,
  parameter int unsigned         FETCH_T  = 3,
  parameter logic [OPCODE_W-1:0] HALT_OP  = '1
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     stall,
  input  logic                     end_early,
`ifdef SINGLE_STEP_EN
  input  logic                     step,
`endif
  input  logic [OPCODE_W-1:0]      ir_op,
  output logic [NUM_T-1:0]         t_state,
  output logic [OPCODE_W-1:0]      op_latched,
  output logic [(2**OPCODE_W)-1:0] dec,
  output logic                     exec,
  output logic                     imm,
  output logic                     retire,
  output logic                     low_halt
);

  localparam logic [NUM_T-1:0] T1_ONEHOT = NUM_T'(1);

  typedef enum logic {
    MODE_RUN,
    MODE_HALTED
  } mode_e;

  mode_e                mode_q, mode_d;
  logic [NUM_T-1:0]     t_q, t_d;
  logic [OPCODE_W-1:0]  op_q, op_d;
  logic                 ret_q, ret_d;
  logic                 step_ok;
  logic                 in_exec;
  logic                 in_halt_check;
  logic                 in_last_fetch;

`ifdef SINGLE_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  assign in_exec       = (mode_q == MODE_RUN) && (|t_q[NUM_T-1:FETCH_T]);
  assign in_halt_check = t_q[FETCH_T];
  assign in_last_fetch = t_q[FETCH_T-1];

  // State register: clr wins over everything, including HALTED
  always_ff @(posedge clk) begin
    if (clr) begin
      mode_q <= MODE_RUN;
      t_q    <= T1_ONEHOT;
      op_q   <= '0;
      ret_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      t_q    <= t_d;
      op_q   <= op_d;
      ret_q  <= ret_d;
    end
  end

  // Next-state: stall > single-step hold > halt check > end of execute > advance
  always_comb begin
    mode_d = mode_q;
    t_d    = t_q;
    op_d   = op_q;
    ret_d  = 1'b0;
    if (mode_q == MODE_RUN) begin
      if (stall) begin
        // hold everything; retire is dropped
      end else if (t_q[0] && !step_ok) begin
        // waiting in T1 for a step pulse
      end else if (in_halt_check && (op_q == HALT_OP)) begin
        mode_d = MODE_HALTED;
        t_d    = '0;
      end else if (in_exec && (end_early || t_q[NUM_T-1])) begin
        // normal wrap and early end share this path, so retire is uniform
        t_d   = T1_ONEHOT;
        ret_d = 1'b1;
      end else begin
        t_d = {t_q[NUM_T-2:0], 1'b0};
        if (in_last_fetch) begin
          op_d = ir_op;
        end
      end
    end
  end

  // Decode outputs are combinational from registered state
  always_comb begin
    dec = '0;
    if (in_exec) begin
      dec[op_q] = 1'b1;
    end
  end

  assign t_state    = t_q;
  assign exec       = in_exec;
  assign imm        = op_q[OPCODE_W-1] & in_exec;
  assign op_latched = (mode_q == MODE_HALTED) ? '0 : op_q;
  assign retire     = ret_q;
  assign low_halt   = (mode_q != MODE_HALTED);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios followed by
// random stimulus, all compared cycle by cycle against a phase-number model.
module tb_control_sequencer;

  localparam int unsigned NUM_T   = 6;
  localparam int unsigned FETCH_T = 3;
  localparam logic [3:0]  HALT    = 4'hF;
`ifdef SINGLE_STEP_EN
  localparam bit HAS_STEP = 1'b1;
`else
  localparam bit HAS_STEP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        stall = 1'b0;
  logic        end_early = 1'b0;
  logic        step_v = 1'b1;
  logic [3:0]  ir_op = '0;
  logic [5:0]  t_state;
  logic [3:0]  op_latched;
  logic [15:0] dec;
  logic        exec, imm, retire, low_halt;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: instruction phase as a plain number 1..NUM_T
  int         m_t    = 1;
  bit         m_halt = 1'b0;
  logic [3:0] m_op   = '0;
  bit         m_ret  = 1'b0;

  control_sequencer #(
    .OPCODE_W(4),
    .NUM_T   (NUM_T),
    .FETCH_T (FETCH_T),
    .HALT_OP (HALT)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .stall     (stall),
    .end_early (end_early),
`ifdef SINGLE_STEP_EN
    .step      (step_v),
`endif
    .ir_op     (ir_op),
    .t_state   (t_state),
    .op_latched(op_latched),
    .dec       (dec),
    .exec      (exec),
    .imm       (imm),
    .retire    (retire),
    .low_halt  (low_halt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit c, input bit s, input bit e, input bit st, input logic [3:0] op);
    bit go;
    go = HAS_STEP ? st : 1'b1;
    if (c) begin
      m_t = 1; m_op = '0; m_ret = 1'b0; m_halt = 1'b0;
    end else if (m_halt) begin
      m_ret = 1'b0;
    end else if (s || (m_t == 1 && !go)) begin
      m_ret = 1'b0;
    end else if (m_t == FETCH_T + 1 && m_op == HALT) begin
      m_halt = 1'b1; m_ret = 1'b0;
    end else if (m_t > FETCH_T && (e || m_t == NUM_T)) begin
      m_t = 1; m_ret = 1'b1;
    end else begin
      if (m_t == FETCH_T) m_op = op;
      m_t = m_t + 1; m_ret = 1'b0;
    end
  endtask

  task automatic check_model();
    bit         ex;
    logic [5:0] et;
    logic [15:0] ed;
    ex = !m_halt && (m_t > FETCH_T);
    et = m_halt ? 6'd0 : 6'(1 << (m_t - 1));
    ed = ex ? 16'(1 << m_op) : 16'd0;
    chk("t_state",    32'(t_state),    32'(et));
    chk("exec",       32'(exec),       32'(ex));
    chk("dec",        32'(dec),        32'(ed));
    chk("imm",        32'(imm),        32'(ex & m_op[3]));
    chk("op_latched", 32'(op_latched), 32'(m_halt ? 4'd0 : m_op));
    chk("retire",     32'(retire),     32'(m_ret));
    chk("low_halt",   32'(low_halt),   32'(!m_halt));
  endtask

  task automatic cyc(input bit c, input bit s, input bit e, input bit st, input logic [3:0] op);
    clr = c; stall = s; end_early = e; step_v = st; ir_op = op;
    @(posedge clk);
    model_edge(c, s, e, st, op);
    #1;
    check_model();
  endtask

  initial begin
    logic [5:0]  seq [6];
    logic [15:0] dseq [6];
    seq  = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
    dseq = '{16'h0, 16'h0, 16'h0010, 16'h0010, 16'h0010, 16'h0};
    #3;

    // 1: reset
    cyc(1, 0, 0, 1, 4'h0);
    cyc(1, 0, 0, 1, 4'h0);
    chk("rst_t", 32'(t_state), 32'h01);
    chk("rst_dec", 32'(dec), 32'h0);
    chk("rst_low_halt", 32'(low_halt), 32'h1);

    // 2: ADD runs T2..T6 and wraps with a retire pulse
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 1, 4'h4);
      chk("add_t", 32'(t_state), 32'(seq[i]));
      chk("add_dec", 32'(dec), 32'(dseq[i]));
    end
    chk("add_retire", 32'(retire), 32'h1);
    cyc(0, 0, 0, 1, 4'h4);
    chk("add_retire_drop", 32'(retire), 32'h0);

    // 3: stall in T2, opcode changed during stall
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 1, 4'($urandom_range(0, 15)));
      chk("stall_t", 32'(t_state), 32'h02);
    end
    cyc(0, 0, 0, 1, 4'h9);
    cyc(0, 0, 0, 1, 4'h6);
    chk("stall_op", 32'(op_latched), 32'h6);
    chk("stall_dec", 32'(dec), 32'h0040);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 4'h1);
    chk("stall_wrap_t", 32'(t_state), 32'h01);

    // 4: end_early in T4 (ignored in T2)
    cyc(0, 0, 0, 1, 4'h0);
    cyc(0, 0, 1, 1, 4'h0);
    chk("ee_fetch_t", 32'(t_state), 32'h04);
    cyc(0, 0, 0, 1, 4'hC);
    chk("ee_dec", 32'(dec), 32'h1000);
    chk("ee_imm", 32'(imm), 32'h1);
    cyc(0, 0, 1, 1, 4'h0);
    chk("ee_t1", 32'(t_state), 32'h01);
    chk("ee_retire", 32'(retire), 32'h1);

    // 5: HALT opcode
    cyc(0, 0, 0, 1, 4'h0);
    cyc(0, 0, 0, 1, 4'h0);
    cyc(0, 0, 0, 1, 4'hF);
    chk("halt_dec", 32'(dec), 32'h8000);
    chk("halt_low_halt_t4", 32'(low_halt), 32'h1);
    cyc(0, 0, 0, 1, 4'h0);
    chk("halt_t", 32'(t_state), 32'h0);
    chk("halt_low_halt", 32'(low_halt), 32'h0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)));
      chk("halt_hold_t", 32'(t_state), 32'h0);
      chk("halt_hold_retire", 32'(retire), 32'h0);
    end
    cyc(1, 0, 0, 1, 4'h0);
    chk("halt_clr_t", 32'(t_state), 32'h01);
    chk("halt_clr_low_halt", 32'(low_halt), 32'h1);

    // 6: clr in T5 of an ADD
    cyc(0, 0, 0, 1, 4'h0);
    cyc(0, 0, 0, 1, 4'h4);
    cyc(0, 0, 0, 1, 4'h4);
    cyc(0, 0, 0, 1, 4'h0);
    chk("clr_mid_t5", 32'(t_state), 32'h10);
    cyc(1, 0, 0, 1, 4'h0);
    chk("clr_mid_t", 32'(t_state), 32'h01);
    chk("clr_mid_op", 32'(op_latched), 32'h0);
    chk("clr_mid_retire", 32'(retire), 32'h0);

`ifdef SINGLE_STEP_EN
    cyc(0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 4'h4);
      chk("step_hold_t", 32'(t_state), 32'h01);
    end
    cyc(0, 0, 0, 1, 4'h4);
    chk("step_go_t", 32'(t_state), 32'h02);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 4'h4);
    chk("step_one_instr_t", 32'(t_state), 32'h01);
    chk("step_one_instr_retire", 32'(retire), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 4'h4);
      chk("step_rehold_t", 32'(t_state), 32'h01);
    end
`endif

    // Random stimulus against the model
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 49) == 0),
          1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 2) != 0),
          4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
